instr_mem_ctrl: RTL
===================

// Module: instr_mem_ctrl
// PURPOSE
//  Parametrised instruction memory for the KGPRisc fetch path, successor to the combinational IMem.
//  Adds a registered read pipeline with valid/ready handshake and a separate program-load write port.
//  Also adds a post-reset init sequencer and byte/word addressing with range/alignment error flagging.
//  Sits between the PC/fetch stage (read side) and the program loader/testbench (write side).
// PARAMETERS
//  DATA_W     32  instruction/data word width
//  ADDR_W     32  width of ra_addr and wa_addr
//  DEPTH      32  number of words stored
//  BYTE_ADDR  0   0: addresses are word indices; 1: byte addresses, index = addr>>2, addr[1:0] must be 0
//  READ_LAT   1   read latency in cycles, legal values 1 or 2
//  INIT_MODE  1   init pattern: 0 = all zero; 1 = mem[i]=i, except mem[0]=0
// PORTS
//  clka       in   1       clock, all logic on rising edge
//  rsta_n     in   1       asynchronous active-low reset
//  init_done  out  1       high once init sequence finished (state RUN)
//  wea        in   1       program-load write enable
//  wa_addr    in   ADDR_W  write address (same addressing mode as read)
//  dina       in   DATA_W  write data
//  ra_valid   in   1       fetch request valid
//  ra_ready   out  1       request accepted when ra_valid & ra_ready
//  ra_addr    in   ADDR_W  fetch address
//  rd_valid   out  1       response valid
//  rd_ready   in   1       consumer accepts response when rd_valid & rd_ready
//  douta      out  DATA_W  instruction word; held stable while rd_valid & !rd_ready
//  rd_err     out  1       response is for an out-of-range or misaligned address; douta = 0
// BEHAVIOUR
//  Reset (async assert, sync deassert use):
//   - rd_valid=0, douta=0, rd_err=0, init_done=0, ra_ready=0.
//   - All pipeline valid bits cleared; FSM to INIT; init counter to 0.
//   - Memory contents are not cleared asynchronously.
//  FSM INIT:
//   - One word per cycle: mem[cnt] <= pattern(cnt); cnt++.
//   - After writing cnt = DEPTH-1 -> RUN; init_done=1 from the next cycle. INIT lasts exactly DEPTH cycles.
//   - wea ignored, ra_ready=0 throughout.
//  FSM RUN:
//   - Stays in RUN until reset.
//   - A reset mid-operation drops in-flight responses and reruns INIT, overwriting loaded program.
//  Address decode:
//   - idx = BYTE_ADDR ? addr>>2 : addr.
//   - Invalid if idx >= DEPTH, or (BYTE_ADDR & addr[1:0]!=0).
//  Write (RUN only):
//   - wea & valid wa_addr -> mem[idx] <= dina at the edge.
//   - Invalid write address silently dropped; no error output.
//  Read pipeline:
//   - READ_LAT stages; all stages advance together.
//   - adv = !rd_valid | rd_ready (output slot free or draining). ra_ready = RUN & adv.
//   - Accepted request with READ_LAT=1: rd_valid=1 next cycle, douta=mem[idx] or 0, rd_err=invalid.
//   - READ_LAT=2: response appears two accepted-advance cycles later; bubbles propagate as invalid stages.
//   - With rd_ready held high: throughput 1 response/cycle, in request order, no loss or duplication.
//   - rd_ready low with rd_valid high: whole pipeline freezes; douta/rd_err/rd_valid hold.
//   - rd_valid falls after handshake only if no new data reaches the output stage.
//  Simultaneous write and read, same idx, same cycle: read returns OLD data (read-first).
//   - A write followed by a read accepted the next cycle returns the new data.
// TESTING
//  1 Reset, INIT_MODE=1, DEPTH=32: init_done rises 32 cycles after rsta_n deasserts.
//    Reads of 0,1,5,31 return 0,1,5,31, rd_err=0.
//  2 READ_LAT=1, rd_ready=1: stream requests 3,4,5 back-to-back.
//    rd_valid high 3 consecutive cycles starting 1 cycle after first accept; douta = 3,4,5.
//  3 Hold rd_ready=0 after first response: ra_ready drops, douta stays 3 for 5 cycles.
//    Release rd_ready -> 4,5 follow with no loss or duplication.
//  4 Write dina=32'hDEADBEEF to 7 while reading 7 in the same cycle -> old value 7.
//    Read 7 next cycle -> 32'hDEADBEEF.
//  5 BYTE_ADDR=1: read 0x14 -> mem[5]; read 0x15 -> rd_err=1, douta=0.
//    Read 0x80 (idx 32) -> rd_err=1; write to 0x80 changes nothing.
//  6 READ_LAT=2 stream with rsta_n pulsed low mid-stream: rd_valid falls immediately (async).
//    INIT reruns; loaded value at 7 restored to 7.

Source files
------------

// File: rtl/instr_mem_ctrl.sv
// instr_mem_ctrl: KGPRisc instruction memory with post-reset init sequencer,
// program-load write port and a valid/ready read pipeline of READ_LAT stages.
`default_nettype none

module instr_mem_ctrl #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int DEPTH     = 32,
  parameter int BYTE_ADDR = 0,
  parameter int READ_LAT  = 1,
  parameter int INIT_MODE = 1
) (
  input  logic              clka,
  input  logic              rsta_n,
  output logic              init_done,
  input  logic              wea,
  input  logic [ADDR_W-1:0] wa_addr,
  input  logic [DATA_W-1:0] dina,
  input  logic              ra_valid,
  output logic              ra_ready,
  input  logic [ADDR_W-1:0] ra_addr,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] douta,
  output logic              rd_err
);

  localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [READ_LAT-1:0] vld_q;
  logic [READ_LAT-1:0] err_q;
  logic [DATA_W-1:0]   dat_q [READ_LAT];

  logic [ADDR_W-1:0] ra_idx, wa_idx;
  logic              ra_bad, wa_bad;
  logic              adv, accept;
  logic [DATA_W-1:0] rd_word;

  function automatic logic [ADDR_W-1:0] word_index(input logic [ADDR_W-1:0] addr);
    return (BYTE_ADDR != 0) ? (addr >> 2) : addr;
  endfunction

  function automatic logic addr_bad(input logic [ADDR_W-1:0] addr);
    return (word_index(addr) >= DEPTH_A) || ((BYTE_ADDR != 0) && (addr[1:0] != 2'b00));
  endfunction

  function automatic logic [DATA_W-1:0] init_pattern(input logic [IDX_W-1:0] idx);
    return (INIT_MODE == 1) ? DATA_W'(idx) : '0;
  endfunction

  assign ra_idx = word_index(ra_addr);
  assign wa_idx = word_index(wa_addr);
  assign ra_bad = addr_bad(ra_addr);
  assign wa_bad = addr_bad(wa_addr);

  assign init_done = (state_q == ST_RUN);
  assign rd_valid  = vld_q[READ_LAT-1];
  assign rd_err    = err_q[READ_LAT-1];
  assign douta     = dat_q[READ_LAT-1];

  // The whole pipeline moves only when the output slot is empty or being drained.
  assign adv      = !rd_valid || rd_ready;
  assign ra_ready = (state_q == ST_RUN) && adv;
  assign accept   = ra_valid && ra_ready;

  // Combinational read sampled at accept gives read-first behaviour on a same-edge write.
  assign rd_word = ra_bad ? '0 : mem[ra_idx[IDX_W-1:0]];

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + IDX_W'(1);
      if (cnt_q == IDX_W'(DEPTH - 1)) begin
        state_d = ST_RUN;
      end
    end
  end

  // Storage has no reset; INIT rewrites every word after each reset.
  always_ff @(posedge clka) begin
    if (state_q == ST_INIT) begin
      mem[cnt_q] <= init_pattern(cnt_q);
    end else if (wea && !wa_bad) begin
      mem[wa_idx[IDX_W-1:0]] <= dina;
    end
  end

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      vld_q <= '0;
      err_q <= '0;
      for (int k = 0; k < READ_LAT; k++) begin
        dat_q[k] <= '0;
      end
    end else if (adv) begin
      vld_q[0] <= accept;
      err_q[0] <= accept && ra_bad;
      dat_q[0] <= accept ? rd_word : '0;
      for (int k = 1; k < READ_LAT; k++) begin
        vld_q[k] <= vld_q[k-1];
        err_q[k] <= err_q[k-1];
        dat_q[k] <= dat_q[k-1];
      end
    end
  end

endmodule

`default_nettype wire
